booth_seq: RTL and testbench

BOOTH_SEQ -- requirements
Module: booth_seq

---
 rtl/booth_pkg.sv | 13 +
 rtl/booth_step.sv | 32 +++
 rtl/booth_seq.sv | 130 +++++++++++++
 tb/tb_booth_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package booth_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of the concatenation {A, Q, Q(-1)}.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q_m1_in,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH-1:0] q_out,
  output logic             q_m1_out
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  // Booth recoding on {Q0, Q(-1)} followed by the arithmetic shift.
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    sum   = a_in;
    case ({q_in[0], q_m1_in})
      2'b01:   sum = a_in + m_ext;
      2'b10:   sum = a_in - m_ext;
      default: sum = a_in;
    endcase
    a_out    = {sum[WIDTH], sum[WIDTH:1]};
    q_out    = {sum[0], q_in[WIDTH-1:1]};
    q_m1_out = q_in[0];
  end

endmodule

// File: rtl/booth_seq.sv
// Sequential signed Booth multiplier: one iteration per clock, started by a
// rising edge of listo, abortable with clr.
//
// state | meaning
// IDLE  | waiting for a listo rising edge
// LOAD  | capture operands, clear accumulator, arm counter
// CALC  | one Booth iteration per cycle, WIDTH cycles
// DONE  | product just updated; done/ack pulse for one cycle
module booth_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 listo,
  input  logic [WIDTH-1:0]     op_A,
  input  logic [WIDTH-1:0]     op_B,
  input  logic                 clr,
  output logic                 busy,
  output logic                 done,
  output logic                 ack,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r, state_nxt;
  logic [WIDTH:0]   a_r, a_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             q_m1_r, q_m1_nxt;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    count_r;
  logic             listo_prev;
  logic             listo_low_seen;
  logic             start;
  logic             last_iter;

  // A listo that was already high when reset released must first fall
  // before its next rise can start a run.
  assign start     = listo & ~listo_prev & listo_low_seen;
  assign last_iter = (count_r == CW'(1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_in     (a_r),
    .q_in     (q_r),
    .q_m1_in  (q_m1_r),
    .m        (m_r),
    .a_out    (a_nxt),
    .q_out    (q_nxt),
    .q_m1_out (q_m1_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt;
  end

  // Next-state logic and status outputs; clr wins over everything.
  always_comb begin
    state_nxt = state_r;
    busy      = 1'b0;
    done      = 1'b0;
    ack       = 1'b0;
    case (state_r)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        busy      = 1'b1;
        state_nxt = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        ack       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clr) state_nxt = ST_IDLE;
  end

  // Datapath: operand capture, iteration, result and listo history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r            <= '0;
      q_r            <= '0;
      q_m1_r         <= 1'b0;
      m_r            <= '0;
      count_r        <= '0;
      product        <= '0;
      valid          <= 1'b0;
      listo_prev     <= 1'b0;
      listo_low_seen <= 1'b0;
    end else begin
      listo_prev <= listo;
      if (!listo) listo_low_seen <= 1'b1;
      if (clr) begin
        product <= '0;
        valid   <= 1'b0;
      end else begin
        case (state_r)
          ST_LOAD: begin
            m_r     <= op_A;
            q_r     <= op_B;
            q_m1_r  <= 1'b0;
            a_r     <= '0;
            count_r <= CW'(WIDTH);
          end
          ST_CALC: begin
            a_r     <= a_nxt;
            q_r     <= q_nxt;
            q_m1_r  <= q_m1_nxt;
            count_r <= count_r - CW'(1);
            if (last_iter) begin
              product <= {a_nxt[WIDTH-1:0], q_nxt};
              valid   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_seq.sv
// Randomized self-checking bench for booth_seq (WIDTH = 8) against a plain
// signed-multiplication reference.
module tb_booth_seq;

  logic        clk;
  logic        rst;
  logic        listo;
  logic [7:0]  op_A;
  logic [7:0]  op_B;
  logic        clr;
  logic        busy;
  logic        done;
  logic        ack;
  logic        valid;
  logic [15:0] product;

  int n_cmp;
  int n_err;

  booth_seq #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .listo   (listo),
    .op_A    (op_A),
    .op_B    (op_B),
    .clr     (clr),
    .busy    (busy),
    .done    (done),
    .ack     (ack),
    .valid   (valid),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = sa * sb;
    return p[15:0];
  endfunction

  // Raise listo, observe `hold` cycles (sampled at negedge), then drop listo.
  // clr_at > 0 asserts clr for one cycle after sample number clr_at.
  task automatic do_run(input logic [7:0] a, input logic [7:0] b, input int hold,
                        input int clr_at, input bit scramble);
    logic [15:0] exp;
    int done_cnt;
    int busy_cnt;
    int ack_cnt;
    int done_at;
    exp      = ref_mul(a, b);
    done_cnt = 0;
    busy_cnt = 0;
    ack_cnt  = 0;
    done_at  = -1;
    op_A  = a;
    op_B  = b;
    listo = 1'b1;
    for (int j = 1; j <= hold; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (ack)  ack_cnt++;
      if (done) begin
        done_cnt++;
        done_at = j;
        check("product_at_done", 32'(product), 32'(exp));
        check("valid_at_done", 32'(valid), 32'd1);
        check("ack_with_done", 32'(ack), 32'd1);
      end
      if (clr_at > 0 && j == clr_at + 1) begin
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_valid", 32'(valid), 32'd0);
        check("clr_product", 32'(product), 32'd0);
      end
      if (scramble && j == 2) begin
        op_A = 8'($urandom);
        op_B = 8'($urandom);
      end
      clr = (clr_at > 0 && j == clr_at);
    end
    clr   = 1'b0;
    listo = 1'b0;
    if (clr_at > 0) begin
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_no_ack", 32'(ack_cnt), 32'd0);
    end else begin
      check("done_count", 32'(done_cnt), 32'd1);
      check("done_latency", 32'(done_at), 32'd10);
      check("busy_cycles", 32'(busy_cnt), 32'd9);
      check("ack_count", 32'(ack_cnt), 32'd1);
      check("product_held", 32'(product), 32'(exp));
      check("valid_held", 32'(valid), 32'd1);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    listo = 1'b0;
    clr   = 1'b0;
    op_A  = '0;
    op_B  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_run(8'd21, 8'd43, 12, 0, 1'b0);
    check("p_21x43", 32'(product), 32'h0387);
    do_run(8'hFB, 8'd7, 12, 0, 1'b1);
    check("p_m5x7", 32'(product), 32'hFFDD);
    do_run(8'd127, 8'h80, 12, 0, 1'b1);
    check("p_127xm128", 32'(product), 32'hC080);
    do_run(8'h80, 8'h80, 12, 0, 1'b0);
    check("p_m128xm128", 32'(product), 32'h4000);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 8 == 0) a = 8'h80;
      if (i % 8 == 1) b = 8'h80;
      if (i % 8 == 2) b = 8'h00;
      do_run(a, b, 12, 0, 1'b1);
    end

    // listo held high far beyond one run must not retrigger
    do_run(8'd100, 8'hC3, 30, 0, 1'b0);

    // abort on the 4th CALC cycle, then a clean run
    do_run(8'd55, 8'd66, 15, 5, 1'b0);
    do_run(8'd55, 8'd66, 12, 0, 1'b0);

    // clr coincident with a listo rise: abort only
    op_A  = 8'd9;
    op_B  = 8'd9;
    listo = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_start_busy", 32'(busy), 32'd0);
    check("clr_start_valid", 32'(valid), 32'd0);
    repeat (12) @(negedge clk);
    check("clr_start_no_run", 32'({busy, done, valid}), 32'd0);
    listo = 1'b0;
    repeat (2) @(negedge clk);

    // asynchronous reset mid-CALC with listo kept high across release
    op_A  = 8'd77;
    op_B  = 8'd3;
    listo = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_outs", 32'({busy, done, ack, valid}), 32'd0);
    check("rst_mid_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int act;
      act = 0;
      repeat (15) begin
        @(negedge clk);
        if (busy || done) act++;
      end
      check("no_start_after_rst", 32'(act), 32'd0);
    end
    listo = 1'b0;
    repeat (2) @(negedge clk);
    do_run(8'd77, 8'd3, 12, 0, 1'b0);
    check("p_after_rst", 32'(product), 32'd231);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
